// File: rtl/bullet_bank_if.sv
// Signal bundle between the bullet engine and its neighbours: the game-phase
// controller and collision checker drive it, the VGA renderer reads it.
interface bullet_bank_if #(
    parameter int NUM_BULLETS = 4,
    parameter int COORD_W     = 8,
    parameter int SIZE_W      = 8
);
    logic                              isRun;
    logic [3*NUM_BULLETS-1:0]          index;
    logic [NUM_BULLETS-1:0]            isCollide;
    logic [2*COORD_W*NUM_BULLETS-1:0]  position;
    logic [2*SIZE_W*NUM_BULLETS-1:0]   size;
    logic [3*NUM_BULLETS-1:0]          color;
    logic [NUM_BULLETS-1:0]            isRender;
    logic [NUM_BULLETS-1:0]            hitPulse;
    logic [7:0]                        hitCount;

    // Game side: controller and collision checker drive, renderer reads.
    modport master (
        output isRun, index, isCollide,
        input  position, size, color, isRender, hitPulse, hitCount
    );

    // Bullet engine side.
    modport slave (
        input  isRun, index, isCollide,
        output position, size, color, isRender, hitPulse, hitCount
    );
endinterface

// File: rtl/bullet_bank.sv
// Multi-channel bullet engine: each channel spawns from a pattern table,
// moves on a shared tick with arena wrap-around, and goes dark for a fixed
// number of ticks after a hit before respawning.
module bullet_bank #(
    parameter int NUM_BULLETS   = 4,
    parameter int COORD_W       = 8,
    parameter int SIZE_W        = 8,
    parameter int TICK_DIV      = 4,
    parameter int ARENA_MIN     = 0,
    parameter int ARENA_MAX     = 200,
    parameter int RESPAWN_TICKS = 8
) (
    input  logic          clk,
    input  logic          resetN,
    bullet_bank_if.slave  bus
);
    localparam int AW = COORD_W + 2;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RESPAWN_TICKS + 1);

    localparam logic signed [AW-1:0] MIN_S = AW'(ARENA_MIN);
    localparam logic signed [AW-1:0] MAX_S = AW'(ARENA_MAX);
    localparam logic signed [AW-1:0] ONE_S = AW'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HIT, RESPAWN} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
        logic [2:0]         col;
    } spawn_t;

    // Registered per-channel state
    state_t             state_q [NUM_BULLETS];
    logic [COORD_W-1:0] x_q     [NUM_BULLETS];
    logic [COORD_W-1:0] y_q     [NUM_BULLETS];
    logic [SIZE_W-1:0]  w_q     [NUM_BULLETS];
    logic [SIZE_W-1:0]  h_q     [NUM_BULLETS];
    logic [2:0]         col_q   [NUM_BULLETS];
    logic [2:0]         lidx_q  [NUM_BULLETS];
    logic [RW-1:0]      resp_q  [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] render_q;
    logic [NUM_BULLETS-1:0] hit_q;
    logic [7:0]             hitcnt_q;
    logic [PW-1:0]          presc_q;

    // Next-state values
    state_t             state_d [NUM_BULLETS];
    logic [COORD_W-1:0] x_d     [NUM_BULLETS];
    logic [COORD_W-1:0] y_d     [NUM_BULLETS];
    logic [SIZE_W-1:0]  w_d     [NUM_BULLETS];
    logic [SIZE_W-1:0]  h_d     [NUM_BULLETS];
    logic [2:0]         col_d   [NUM_BULLETS];
    logic [2:0]         lidx_d  [NUM_BULLETS];
    logic [RW-1:0]      resp_d  [NUM_BULLETS];
    logic [7:0]             hitcnt_d;
    logic [PW-1:0]          presc_d;
    logic                   tick;

    // Pattern table: spawn point, size and colour for a given index/channel.
    function automatic spawn_t spawn_of(input logic [2:0] idx, input int ch);
        logic [COORD_W-1:0] lo;
        logic [COORD_W-1:0] hi;
        logic [COORD_W-1:0] off;
        spawn_t s;
        lo  = COORD_W'(ARENA_MIN);
        hi  = COORD_W'(ARENA_MAX);
        off = COORD_W'(16 * ch);
        case (idx[1:0])
            2'd0:    s = '{x: lo,       y: lo + off, w: SIZE_W'(8), h: SIZE_W'(8),  col: 3'b000};
            2'd1:    s = '{x: hi,       y: lo + off, w: SIZE_W'(8), h: SIZE_W'(8),  col: 3'b001};
            2'd2:    s = '{x: lo + off, y: lo,       w: SIZE_W'(4), h: SIZE_W'(12), col: 3'b010};
            default: s = '{x: lo + off, y: lo,       w: SIZE_W'(6), h: SIZE_W'(6),  col: 3'b000};
        endcase
        return s;
    endfunction

    function automatic logic signed [AW-1:0] vel_x(input logic [2:0] idx);
        case (idx[1:0])
            2'd0:    vel_x = AW'(2);
            2'd1:    vel_x = AW'(-2);
            2'd2:    vel_x = AW'(0);
            default: vel_x = AW'(1);
        endcase
    endfunction

    function automatic logic signed [AW-1:0] vel_y(input logic [2:0] idx);
        case (idx[1:0])
            2'd2:    vel_y = AW'(3);
            2'd3:    vel_y = AW'(1);
            default: vel_y = AW'(0);
        endcase
    endfunction

    // One axis step with wrap; landing exactly on MIN or MAX stays put.
    function automatic logic [COORD_W-1:0] step_axis(input logic [COORD_W-1:0] cur,
                                                     input logic signed [AW-1:0] vel);
        logic signed [AW-1:0] nv;
        logic signed [AW-1:0] res;
        nv = $signed({2'b00, cur}) + vel;
        if (nv > MAX_S)
            res = MIN_S + (nv - MAX_S - ONE_S);
        else if (nv < MIN_S)
            res = MAX_S - (MIN_S - nv - ONE_S);
        else
            res = nv;
        return res[COORD_W-1:0];
    endfunction

    // Shared prescaler; tick only while running so frozen state never advances.
    always_comb begin
        tick    = bus.isRun && (presc_q == PW'(TICK_DIV - 1));
        presc_d = presc_q;
        if (bus.isRun)
            presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Per-channel next-state and datapath, plus the hit accumulator.
    always_comb begin
        logic [3:0] n_hits;
        logic [8:0] sum;
        n_hits = '0;
        for (int ch = 0; ch < NUM_BULLETS; ch++) begin
            logic [2:0] idx_in;
            logic       valid;
            spawn_t     sp;
            // NOTE: every combinational output gets a default first so no path
            // through the case leaves it unassigned, which would infer a latch.
            state_d[ch] = state_q[ch];
            x_d[ch]     = x_q[ch];
            y_d[ch]     = y_q[ch];
            w_d[ch]     = w_q[ch];
            h_d[ch]     = h_q[ch];
            col_d[ch]   = col_q[ch];
            lidx_d[ch]  = lidx_q[ch];
            resp_d[ch]  = resp_q[ch];
            idx_in      = bus.index[3*ch +: 3];
            valid       = !idx_in[2];
            sp          = spawn_of(idx_in, ch);

            case (state_q[ch])
                IDLE: begin
                    if (bus.isRun && valid) begin
                        state_d[ch] = ACTIVE;
                        {x_d[ch], y_d[ch], w_d[ch], h_d[ch], col_d[ch]} = sp;
                        lidx_d[ch]  = idx_in;
                    end
                end
                ACTIVE: begin
                    if (bus.isCollide[ch]) begin
                        state_d[ch] = HIT;
                    end else if (!valid) begin
                        state_d[ch] = IDLE;
                    end else if (idx_in != lidx_q[ch]) begin
                        {x_d[ch], y_d[ch], w_d[ch], h_d[ch], col_d[ch]} = sp;
                        lidx_d[ch]  = idx_in;
                    end else if (tick) begin
                        x_d[ch] = step_axis(x_q[ch], vel_x(lidx_q[ch]));
                        y_d[ch] = step_axis(y_q[ch], vel_y(lidx_q[ch]));
                    end
                end
                HIT: begin
                    resp_d[ch]  = RW'(RESPAWN_TICKS);
                    state_d[ch] = RESPAWN;
                end
                default: begin
                    if (tick) begin
                        if (resp_q[ch] <= RW'(1)) begin
                            resp_d[ch] = '0;
                            if (valid) begin
                                state_d[ch] = ACTIVE;
                                {x_d[ch], y_d[ch], w_d[ch], h_d[ch], col_d[ch]} = sp;
                                lidx_d[ch]  = idx_in;
                            end else begin
                                state_d[ch] = IDLE;
                            end
                        end else begin
                            resp_d[ch] = resp_q[ch] - RW'(1);
                        end
                    end
                end
            endcase

            if (state_d[ch] == HIT)
                n_hits = n_hits + 4'd1;
        end
        sum      = {1'b0, hitcnt_q} + {5'b00000, n_hits};
        hitcnt_d = sum[8] ? 8'hFF : sum[7:0];
    end

    // State register; every channel register is cleared so reset fully defines outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (!resetN) begin
            presc_q  <= '0;
            hitcnt_q <= '0;
            render_q <= '0;
            hit_q    <= '0;
            for (int ch = 0; ch < NUM_BULLETS; ch++) begin
                state_q[ch] <= IDLE;
                x_q[ch]     <= '0;
                y_q[ch]     <= '0;
                w_q[ch]     <= '0;
                h_q[ch]     <= '0;
                col_q[ch]   <= '0;
                lidx_q[ch]  <= '0;
                resp_q[ch]  <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            hitcnt_q <= hitcnt_d;
            for (int ch = 0; ch < NUM_BULLETS; ch++) begin
                state_q[ch]  <= state_d[ch];
                x_q[ch]      <= x_d[ch];
                y_q[ch]      <= y_d[ch];
                w_q[ch]      <= w_d[ch];
                h_q[ch]      <= h_d[ch];
                col_q[ch]    <= col_d[ch];
                lidx_q[ch]   <= lidx_d[ch];
                resp_q[ch]   <= resp_d[ch];
                render_q[ch] <= (state_d[ch] == ACTIVE);
                hit_q[ch]    <= (state_d[ch] == HIT);
            end
        end
    end

    // Pack registered channel state onto the output buses.
    always_comb begin
        bus.position = '0;
        bus.size     = '0;
        bus.color    = '0;
        for (int ch = 0; ch < NUM_BULLETS; ch++) begin
            bus.position[2*COORD_W*ch +: 2*COORD_W] = {x_q[ch], y_q[ch]};
            bus.size[2*SIZE_W*ch +: 2*SIZE_W]       = {w_q[ch], h_q[ch]};
            bus.color[3*ch +: 3]                    = col_q[ch];
        end
        bus.isRender = render_q;
        bus.hitPulse = hit_q;
        bus.hitCount = hitcnt_q;
    end
endmodule

// File: tb/tb_bullet_bank.sv
// Directed bench for bullet_bank with two channels: spawn, movement, wrap at
// both arena edges, hit/respawn, hit-count saturation, pattern changes,
// freeze and reset during a hit.
module tb_bullet_bank;
    localparam int NB = 2;
    localparam int CW = 8;
    localparam int SW = 8;

    logic clk;
    logic resetN;
    int   checks;
    int   failures;
    int   exp_cnt;

    bullet_bank_if #(.NUM_BULLETS(NB), .COORD_W(CW), .SIZE_W(SW)) bus ();

    bullet_bank #(
        .NUM_BULLETS(NB), .COORD_W(CW), .SIZE_W(SW), .TICK_DIV(4),
        .ARENA_MIN(0), .ARENA_MAX(200), .RESPAWN_TICKS(8)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] px(input int ch);
        return 32'(bus.position[2*CW*ch + CW +: CW]);
    endfunction
    function automatic logic [31:0] py(input int ch);
        return 32'(bus.position[2*CW*ch +: CW]);
    endfunction
    function automatic logic [31:0] sw(input int ch);
        return 32'(bus.size[2*SW*ch + SW +: SW]);
    endfunction
    function automatic logic [31:0] sh(input int ch);
        return 32'(bus.size[2*SW*ch +: SW]);
    endfunction
    function automatic logic [31:0] cl(input int ch);
        return 32'(bus.color[3*ch +: 3]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n edges and sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_render(input logic [NB-1:0] mask);
        int n;
        n = 0;
        while (((bus.isRender & mask) !== mask) && n < 100) begin
            step(1);
            n++;
        end
        check("wait_render", 32'(bus.isRender & mask), 32'(mask));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        resetN    = 1'b0;
        bus.isRun = 1'b0;
        bus.index = '0;
        bus.isCollide = '0;
        step(2);
        check("rst_pos",    32'(bus.position), 0);
        check("rst_size",   32'(bus.size), 0);
        check("rst_color",  32'(bus.color), 0);
        check("rst_render", 32'(bus.isRender), 0);
        check("rst_pulse",  32'(bus.hitPulse), 0);
        check("rst_count",  32'(bus.hitCount), 0);

        // Spawn and move
        resetN    = 1'b1;
        bus.isRun = 1'b1;
        bus.index = 6'b000_000;
        step(1);
        check("spawn_render", 32'(bus.isRender), 3);
        check("spawn_x0", px(0), 0);
        check("spawn_y0", py(0), 0);
        check("spawn_x1", px(1), 0);
        check("spawn_y1", py(1), 16);
        check("spawn_w0", sw(0), 8);
        check("spawn_h0", sh(0), 8);
        check("spawn_col0", cl(0), 0);
        step(3);
        check("move1_x0", px(0), 2);
        check("move1_y1", py(1), 16);
        step(36);
        check("move10_x0", px(0), 20);

        // Wrap at MAX
        step(360);
        check("at_max_x0", px(0), 200);
        check("at_max_x1", px(1), 200);
        step(4);
        check("wrap_x0", px(0), 1);
        step(4);
        check("wrap2_x0", px(0), 3);

        // Hit and respawn on channel 0
        bus.isCollide = 2'b01;
        step(1);
        check("hit_pulse", 32'(bus.hitPulse), 1);
        check("hit_render", 32'(bus.isRender), 2);
        check("hit_count", 32'(bus.hitCount), 1);
        bus.isCollide = 2'b00;
        step(1);
        check("hit_pulse_end", 32'(bus.hitPulse), 0);
        check("hit_dark", 32'(bus.isRender[0]), 0);
        bus.isCollide = 2'b01;
        step(1);
        bus.isCollide = 2'b00;
        check("resp_ignore_pulse", 32'(bus.hitPulse), 0);
        check("resp_ignore_count", 32'(bus.hitCount), 1);
        step(28);
        check("resp_still_dark", 32'(bus.isRender[0]), 0);
        step(1);
        check("resp_visible", 32'(bus.isRender[0]), 1);
        check("resp_x0", px(0), 0);
        check("resp_y0", py(0), 0);

        // Simultaneous hits and saturation
        bus.isCollide = 2'b11;
        step(1);
        bus.isCollide = 2'b00;
        check("dbl_pulse", 32'(bus.hitPulse), 3);
        check("dbl_count", 32'(bus.hitCount), 3);
        wait_render(2'b11);
        bus.isCollide = 2'b01;
        step(1);
        bus.isCollide = 2'b00;
        check("single_count", 32'(bus.hitCount), 4);
        exp_cnt = 4;
        for (int i = 0; i < 125; i++) begin
            wait_render(2'b11);
            bus.isCollide = 2'b11;
            step(1);
            bus.isCollide = 2'b00;
            exp_cnt += 2;
            check("preload_count", 32'(bus.hitCount), 32'(exp_cnt));
        end
        wait_render(2'b11);
        bus.isCollide = 2'b11;
        step(1);
        bus.isCollide = 2'b00;
        check("sat_pulse", 32'(bus.hitPulse), 3);
        check("sat_count", 32'(bus.hitCount), 255);
        wait_render(2'b11);
        bus.isCollide = 2'b01;
        step(1);
        bus.isCollide = 2'b00;
        check("sat_hold_pulse", 32'(bus.hitPulse), 1);
        check("sat_hold_count", 32'(bus.hitCount), 255);

        // Index change mid-flight
        wait_render(2'b11);
        bus.index = 6'b000_010;
        step(1);
        check("chg_render", 32'(bus.isRender[0]), 1);
        check("chg_x0", px(0), 0);
        check("chg_y0", py(0), 0);
        check("chg_w0", sw(0), 4);
        check("chg_h0", sh(0), 12);
        check("chg_col0", cl(0), 2);
        bus.index = 6'b000_101;
        step(1);
        check("inv_render", 32'(bus.isRender[0]), 0);
        step(1);
        check("inv_idle", 32'(bus.isRender[0]), 0);
        bus.index = 6'b000_001;
        step(1);
        check("p1_render", 32'(bus.isRender[0]), 1);
        check("p1_x0", px(0), 200);
        check("p1_y0", py(0), 0);
        check("p1_col0", cl(0), 1);
        step(4);
        check("p1_move_x0", px(0), 198);
        step(396);
        check("p1_at_min_x0", px(0), 0);
        step(4);
        check("p1_wrap_x0", px(0), 199);

        // Freeze: hit ch0 and reload ch1 to pattern 3 while stopped
        bus.isRun     = 1'b0;
        bus.index     = 6'b011_001;
        bus.isCollide = 2'b01;
        step(1);
        bus.isCollide = 2'b00;
        check("frz_pulse", 32'(bus.hitPulse), 1);
        check("frz_render", 32'(bus.isRender), 2);
        check("frz_x1", px(1), 16);
        check("frz_y1", py(1), 0);
        check("frz_w1", sw(1), 6);
        step(20);
        check("frz_hold_x1", px(1), 16);
        check("frz_hold_y1", py(1), 0);
        check("frz_hold_dark", 32'(bus.isRender[0]), 0);
        bus.isRun = 1'b1;
        wait_render(2'b01);
        check("unfrz_x1", px(1), 24);
        check("unfrz_y1", py(1), 8);
        check("unfrz_x0", px(0), 200);
        check("unfrz_y0", py(0), 0);

        // Reset during a HIT cycle
        bus.isCollide = 2'b01;
        step(1);
        bus.isCollide = 2'b00;
        check("pre_rst_pulse", 32'(bus.hitPulse), 1);
        resetN = 1'b0;
        step(1);
        check("mid_rst_pos",    32'(bus.position), 0);
        check("mid_rst_size",   32'(bus.size), 0);
        check("mid_rst_color",  32'(bus.color), 0);
        check("mid_rst_render", 32'(bus.isRender), 0);
        check("mid_rst_pulse",  32'(bus.hitPulse), 0);
        check("mid_rst_count",  32'(bus.hitCount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
